// File: rtl/apple_bus_timing.sv
// rtl/apple_bus_timing.sv - Apple II PHI0/2M bus phase recovery with edge strobes, phase counter and lock monitor.
// Pins are synchronized; PHI0 is additionally deglitched before edge detection.
module apple_bus_timing #(
  parameter int SYNC_STAGES      = 2,
  parameter int GLITCH_FILTER    = 3,
  parameter int MIN_PHASE_CYCLES = 20,
  parameter int MAX_PHASE_CYCLES = 30,
  parameter int LOCK_PHASES      = 8
) (
  input  logic       clk_logic,
  input  logic       rst_n,
  input  logic       a2_phi0_i,
  input  logic       a2_2m_i,
  output logic       phi0_o,
  output logic       phi1_o,
  output logic       phi0_posedge_o,
  output logic       phi0_negedge_o,
  output logic       phi1_posedge_o,
  output logic       phi1_negedge_o,
  output logic       clk_2m_posedge_o,
  output logic       clk_2m_negedge_o,
  output logic [5:0] phase_count_o,
  output logic       locked_o,
  output logic       clock_lost_o
);

  localparam int RUN_W  = $clog2(GLITCH_FILTER + 1);
  localparam int GOOD_W = $clog2(LOCK_PHASES + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(GLITCH_FILTER - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_PHASES - 1);
  localparam logic [5:0] CNT_MIN = 6'(MIN_PHASE_CYCLES - 1);
  localparam logic [5:0] CNT_MAX = 6'(MAX_PHASE_CYCLES - 1);
  localparam logic [5:0] CNT_SAT = 6'd63;

  typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} lock_state_e;

  logic [SYNC_STAGES-1:0] phi0_sync_q, m2_sync_q;
  logic                   m2_hist_q, m2_rise_q, m2_fall_q;
  logic [RUN_W-1:0]       run_q, run_d;
  logic                   level_q, level_d, flip;
  logic                   phi0_rise_q, phi0_fall_q;
  logic [5:0]             count_q, count_d;
  lock_state_e            state_q, state_d;
  logic [GOOD_W-1:0]      good_q, good_d;
  logic                   phi0_s, m2_s, phi0_edge, phase_legal;

  assign phi0_s = phi0_sync_q[SYNC_STAGES-1];
  assign m2_s   = m2_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_logic or negedge rst_n) begin
    if (!rst_n) begin
      phi0_sync_q <= '0;
      m2_sync_q   <= '0;
      m2_hist_q   <= 1'b0;
      m2_rise_q   <= 1'b0;
      m2_fall_q   <= 1'b0;
      run_q       <= '0;
      level_q     <= 1'b0;
      phi0_rise_q <= 1'b0;
      phi0_fall_q <= 1'b0;
      count_q     <= '0;
    end else begin
      phi0_sync_q <= {phi0_sync_q[SYNC_STAGES-2:0], a2_phi0_i};
      m2_sync_q   <= {m2_sync_q[SYNC_STAGES-2:0], a2_2m_i};
      m2_hist_q   <= m2_s;
      m2_rise_q   <= m2_s & ~m2_hist_q;
      m2_fall_q   <= ~m2_s & m2_hist_q;
      run_q       <= run_d;
      level_q     <= level_d;
      phi0_rise_q <= flip & level_d;
      phi0_fall_q <= flip & ~level_d;
      count_q     <= count_d;
    end
  end

  // Run of samples disagreeing with the filtered level; any agreeing sample restarts it.
  always_comb begin
    run_d   = '0;
    level_d = level_q;
    flip    = 1'b0;
    if (phi0_s != level_q) begin
      if (run_q == RUN_LAST) begin
        flip    = 1'b1;
        level_d = phi0_s;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  assign phi0_edge   = phi0_rise_q | phi0_fall_q;
  assign count_d     = phi0_edge ? 6'd0 : ((count_q == CNT_SAT) ? CNT_SAT : count_q + 6'd1);
  // count_q during the strobe cycle is the just-finished phase length minus one.
  assign phase_legal = (count_q >= CNT_MIN) && (count_q <= CNT_MAX);

  always_ff @(posedge clk_logic or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNLOCKED;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (phi0_edge) begin
      case (state_q)
        ST_UNLOCKED: begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
        ST_ACQUIRE: begin
          if (!phase_legal) begin
            good_d = '0;
          end else if (good_q == GOOD_LAST) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!phase_legal) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          good_d  = '0;
        end
      endcase
    end else if (count_d == CNT_SAT) begin
      state_d = ST_UNLOCKED;
      good_d  = '0;
    end
  end

  always_comb begin
    locked_o = (state_q == ST_LOCKED);
  end

  assign phi0_o           = level_q;
  assign phi1_o           = ~level_q;
  assign phi0_posedge_o   = phi0_rise_q;
  assign phi0_negedge_o   = phi0_fall_q;
  assign phi1_posedge_o   = phi0_fall_q;
  assign phi1_negedge_o   = phi0_rise_q;
  assign clk_2m_posedge_o = m2_rise_q;
  assign clk_2m_negedge_o = m2_fall_q;
  assign phase_count_o    = count_q;
  assign clock_lost_o     = (count_q == CNT_SAT);

endmodule

// File: tb/tb_apple_bus_timing.sv
// tb/tb_apple_bus_timing.sv - Self-checking bench for apple_bus_timing against a behavioural phase model.
module tb_apple_bus_timing;
  localparam int SS   = 2;
  localparam int GF   = 3;
  localparam int MINP = 20;
  localparam int MAXP = 30;
  localparam int LP   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic phi_pin = 1'b0;
  logic m2_pin = 1'b0;
  logic phi0_o, phi1_o, phi0_posedge_o, phi0_negedge_o, phi1_posedge_o, phi1_negedge_o;
  logic clk_2m_posedge_o, clk_2m_negedge_o, locked_o, clock_lost_o;
  logic [5:0] phase_count_o;

  apple_bus_timing #(
    .SYNC_STAGES(SS), .GLITCH_FILTER(GF), .MIN_PHASE_CYCLES(MINP),
    .MAX_PHASE_CYCLES(MAXP), .LOCK_PHASES(LP)
  ) dut (
    .clk_logic(clk), .rst_n(rst_n), .a2_phi0_i(phi_pin), .a2_2m_i(m2_pin),
    .phi0_o(phi0_o), .phi1_o(phi1_o), .phi0_posedge_o(phi0_posedge_o),
    .phi0_negedge_o(phi0_negedge_o), .phi1_posedge_o(phi1_posedge_o),
    .phi1_negedge_o(phi1_negedge_o), .clk_2m_posedge_o(clk_2m_posedge_o),
    .clk_2m_negedge_o(clk_2m_negedge_o), .phase_count_o(phase_count_o),
    .locked_o(locked_o), .clock_lost_o(clock_lost_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pin history per clock since reset release, outputs derived from it.
  logic ph [0:65535];
  logic pm [0:65535];
  int   n = 0, last_strobe = 0, streak = 0, m_count = 0;
  bit   has_strobe = 0, tracking = 0;
  logic m_level = 0, m_pos = 0, m_neg = 0, m_m2p = 0, m_m2n = 0, m_locked = 0;

  function automatic logic phb(input int i);
    return (i >= 1) ? ph[i] : 1'b0;
  endfunction
  function automatic logic pmb(input int i);
    return (i >= 1) ? pm[i] : 1'b0;
  endfunction

  initial begin
    logic strobe_now;
    int   cnt_now;
    bit   all_diff;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; last_strobe = 0; streak = 0; m_count = 0;
        has_strobe = 0; tracking = 0;
        m_level = 0; m_pos = 0; m_neg = 0; m_m2p = 0; m_m2n = 0; m_locked = 0;
      end else begin
        n++;
        ph[n] = phi_pin;
        pm[n] = m2_pin;
        strobe_now = m_pos | m_neg;
        cnt_now    = m_count;
        if (strobe_now) begin
          if (!tracking) begin
            tracking = 1; streak = 0;
          end else if (cnt_now + 1 >= MINP && cnt_now + 1 <= MAXP) begin
            streak++;
          end else begin
            streak = 0;
          end
          last_strobe = n - 1;
          has_strobe  = 1;
        end
        m_count = has_strobe ? (n - last_strobe - 1) : n;
        if (m_count > 63) m_count = 63;
        if (!strobe_now && m_count == 63) begin
          tracking = 0; streak = 0;
        end
        m_locked = tracking && (streak >= LP);
        m_pos = 0; m_neg = 0;
        if (n >= GF) begin
          all_diff = 1;
          for (int j = 0; j < GF; j++) if (phb(n - j - SS) == m_level) all_diff = 0;
          if (all_diff) begin
            m_level = ~m_level;
            m_pos = m_level;
            m_neg = ~m_level;
          end
        end
        m_m2p = pmb(n - SS) & ~pmb(n - SS - 1);
        m_m2n = ~pmb(n - SS) & pmb(n - SS - 1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("phi0_o", phi0_o, m_level);
      check("phi1_o", phi1_o, !m_level);
      check("phi0_posedge_o", phi0_posedge_o, m_pos);
      check("phi0_negedge_o", phi0_negedge_o, m_neg);
      check("phi1_posedge_o", phi1_posedge_o, m_neg);
      check("phi1_negedge_o", phi1_negedge_o, m_pos);
      check("clk_2m_posedge_o", clk_2m_posedge_o, m_m2p);
      check("clk_2m_negedge_o", clk_2m_negedge_o, m_m2n);
      check("phase_count_o", phase_count_o, m_count);
      check("locked_o", locked_o, m_locked);
      check("clock_lost_o", clock_lost_o, m_count == 63);
    end
  end

  // Event timestamps for relative-latency checks.
  int   cyc = 0, strobe_cyc = 0, rise_cyc = 0, fall_cyc = 0, lost_cyc = 0, cnt_at_strobe = 0;
  logic lk_prev = 0, lost_prev = 0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (phi0_posedge_o || phi0_negedge_o) begin
        strobe_cyc = cyc;
        cnt_at_strobe = phase_count_o;
      end
      if (locked_o && !lk_prev) rise_cyc = cyc;
      if (!locked_o && lk_prev) fall_cyc = cyc;
      if (clock_lost_o && !lost_prev) lost_cyc = cyc;
      lk_prev = locked_o;
      lost_prev = clock_lost_o;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic run_phase(input int len);
    @(negedge clk);
    phi_pin = ~phi_pin;
    m2_pin = ~m2_pin;
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      if (i == len / 2) m2_pin = ~m2_pin;
    end
  endtask

  task automatic run_phase_noisy(input int len);
    int g, w, t;
    g = $urandom_range(4, len - 6);
    w = $urandom_range(1, 2);
    t = $urandom_range(1, len - 1);
    @(negedge clk);
    phi_pin = ~phi_pin;
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      if (i == g || i == g + w) phi_pin = ~phi_pin;
      if (i == t) m2_pin = ~m2_pin;
    end
  endtask

  task automatic relock_check(input string tag, input int len_a, input int len_b);
    for (int i = 1; i <= LP; i++) begin
      run_phase((i % 2 == 1) ? len_a : len_b);
      if (i == LP - 1) check({tag, "_unlocked_at_7"}, locked_o, 0);
    end
    check({tag, "_locked_at_8"}, locked_o, 1);
  endtask

  initial begin
    int k;
    bit seen;
    tick(3);
    check("rst_phi0", phi0_o, 0);
    check("rst_phi1", phi1_o, 1);
    check("rst_count", phase_count_o, 0);
    check("rst_locked", locked_o, 0);
    check("rst_lost", clock_lost_o, 0);
    rst_n = 1'b1;
    m2_pin = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (clk_2m_posedge_o) begin k = i; break; end
    end
    check("m2_latency", k, 3);
    @(negedge clk);
    check("m2_strobe_width", clk_2m_posedge_o, 0);
    tick(2);

    phi_pin = 1'b1;
    tick(2);
    phi_pin = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (phi0_o || phi0_posedge_o) seen = 1;
    end
    check("glitch_ignored", seen, 0);

    phi_pin = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (phi0_posedge_o) begin k = i; break; end
    end
    check("step_latency", k, 5);
    check("step_level", phi0_o, 1);
    @(negedge clk);
    check("strobe_width", phi0_posedge_o, 0);
    tick(18);

    relock_check("nominal", 24, 25);
    #1;
    check("lock_rise_delay", rise_cyc - strobe_cyc, 1);
    check("count_at_strobe", cnt_at_strobe, 23);

    run_phase(15);
    run_phase(25);
    #1;
    check("short_unlocks", locked_o, 0);
    check("unlock_delay", fall_cyc - strobe_cyc, 1);
    check("count_at_short", cnt_at_strobe, 14);
    for (int i = 1; i <= LP; i++) begin
      run_phase($urandom_range(MINP, MAXP));
      if (i == LP - 1) check("relock_unlocked_at_7", locked_o, 0);
    end
    check("relock_locked_at_8", locked_o, 1);

    run_phase(31);
    run_phase(24);
    #1;
    check("long_unlocks", locked_o, 0);
    check("count_at_long", cnt_at_strobe, 30);
    relock_check("bounds", MINP, MAXP);

    for (int i = 0; i < 60; i++) run_phase_noisy($urandom_range(12, 40));

    for (int i = 0; i < 10; i++) run_phase(25);
    check("locked_before_loss", locked_o, 1);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (clock_lost_o) begin k = i; break; end
    end
    check("loss_seen", k > 0, 1);
    check("loss_count", phase_count_o, 63);
    check("loss_locked", locked_o, 0);
    #1;
    check("loss_delay", lost_cyc - strobe_cyc, 64);
    check("loss_same_cycle", fall_cyc, lost_cyc);
    run_phase(25);
    check("lost_cleared", clock_lost_o, 0);
    check("restart_unlocked", locked_o, 0);
    relock_check("restart", 25, 24);

    @(negedge clk);
    if (phi_pin) phi_pin = 1'b0;
    else phi_pin = 1'b1;
    if (!phi_pin) run_phase(25);
    tick(10);
    check("pre_reset_phi0", phi0_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_phi0", phi0_o, 0);
    check("mid_rst_phi1", phi1_o, 1);
    check("mid_rst_locked", locked_o, 0);
    check("mid_rst_count", phase_count_o, 0);
    check("mid_rst_strobe", phi0_posedge_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (phi0_posedge_o) begin k = i; break; end
    end
    check("release_latency", k, 5);
    check("release_unlocked", locked_o, 0);
    tick(19);
    relock_check("post_reset", 24, 25);

    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
